instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage. Owns the program counter, drives address/read-enable of the 16-bit instruction
//  memory, and registers the returned word into the IF/ID pipeline register for decode.
//  Handles stall, flush, branch/jump redirect and (optional) halt detection.
//  Memory returns the word for im_addr during the clock-high phase of the same cycle.
//  Fetch captures that word on the next rising edge.
// PARAMETERS
//  ADDR_W       16       PC / memory address width
//  INSTR_W      16       instruction width
//  RESET_PC     16'h0000 PC value after reset
//  NOP_INSTR    16'h0000 bubble encoding loaded into IF/ID on flush/halt
//  HALT_OPCODE  4'hF     opcode (instr[15:12]) treated as HLT
// PORTS
//  clk          in   1        system clock, all state on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  stall        in   1        hold PC and IF/ID (hazard unit)
//  flush        in   1        squash IF/ID contents this edge
//  redirect     in   1        load PC from redirect_pc (taken branch/jump)
//  redirect_pc  in   ADDR_W   redirect target
//  im_instr     in   INSTR_W  word returned by instruction memory
//  im_addr      out  ADDR_W   memory address (= PC, combinational)
//  im_rd_en     out  1        memory read enable
//  if_instr     out  INSTR_W  IF/ID instruction
//  if_pc_plus1  out  ADDR_W   IF/ID PC+1 of that instruction (link/branch base)
//  if_valid     out  1        IF/ID holds a real instruction
//  halted       out  1        fetch stopped on HLT
// BEHAVIOUR
//  Reset: pc=RESET_PC, if_instr=NOP_INSTR, if_pc_plus1=0, if_valid=0, halted=0, state=IDLE.
//  FSM IDLE -> FETCH unconditionally after 1 cycle (memory settle). IDLE: im_rd_en=0, IF/ID gets bubble.
//  FETCH -> HALT when im_instr[15:12]==HALT_OPCODE, no stall and no redirect.
//  HALT -> FETCH only on redirect (HLT was wrong-path). Otherwise HALT holds until reset.
//  im_rd_en = (state==FETCH) & ~stall.
//  PC next-value priority: redirect > stall (hold) > HALT entry/HALT (hold) > pc+1.
//    Redirect overrides stall.
//  pc+1 wraps mod 2^ADDR_W (16'hFFFF -> 16'h0000).
//  IF/ID priority: flush or redirect -> {NOP_INSTR,valid=0}. Flush beats stall.
//    Then stall -> hold. Then FETCH -> {im_instr, pc+1, valid=1}. Otherwise bubble.
//  HLT itself enters IF/ID with valid=1. PC freezes at the HLT address.
//  halted=1 from the edge that enters HALT.
//  Latency: word at PC appears on if_instr 1 edge after im_addr=PC with stall=0.
//  Throughput: 1 instr/cycle.
//  Reset asserted mid-operation: all state returns to reset values immediately (async).
//    Nothing in flight survives.
// CONFIGURATION
//  HALT_DETECT_EN defined: HALT state and halted output as above.
//  Not defined: no HALT state, halted tied 0. HLT opcode is fetched like any other
//    instruction and PC keeps incrementing.
// STRUCTURE
//  fetch_pkg: fetch_state_t enum {IDLE,FETCH,HALT}, NOP_INSTR, HALT_OPCODE,
//    OPCODE_MSB/LSB field constants.
//  Sub-module if_id_reg: IF/ID register with load/hold/squash controls and async reset.
//    PC + FSM stay in instr_fetch.
// TESTING
//  Reset release, mem[0..3]=1111,2222,3333,4444 -> im_rd_en low 1 cycle.
//    Then if_instr 1111,2222,3333 on successive edges, if_pc_plus1 1,2,3.
//  stall high 2 cycles at PC=2 -> im_addr stays 2, if_instr/if_valid held.
//    Resumes with 3333, no word lost or duplicated.
//  redirect=1, redirect_pc=0x0100, with stall=1 -> next im_addr=0x0100, if_valid=0.
//    Next edge if_instr=mem[0x100].
//  flush=1 with stall=1 -> if_instr=0000, if_valid=0, PC held.
//  PC=0xFFFF streaming -> next im_addr=0x0000, if_pc_plus1=0x0000.
//  HALT_DETECT_EN: mem[5]=F000 -> halted=1, im_addr frozen 5, if_valid=0 after HLT.
//    redirect to 0x0010 -> halted=0, fetch resumes at 0x0010.
//    Without macro -> PC proceeds to 6, halted=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM states, bubble encoding, HLT opcode field.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} fetch_state_t;

  localparam logic [15:0]  NOP_INSTR   = 16'h0000;
  localparam logic [3:0]   HALT_OPCODE = 4'hF;
  localparam int unsigned  OPCODE_MSB  = 15;
  localparam int unsigned  OPCODE_LSB  = 12;

  // True when the 16-bit word carries the HLT opcode
  function automatic logic is_hlt(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: squash beats hold, hold beats load, otherwise a bubble is inserted.
module if_id_reg #(
  parameter int unsigned          ADDR_W    = 16,
  parameter int unsigned          INSTR_W   = 16,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               squash,
  input  logic               hold,
  input  logic               load,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_plus1_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_plus1_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_plus1_q, pc_plus1_d;
  logic               valid_q, valid_d;

  always_comb begin
    instr_d    = NOP_INSTR;
    pc_plus1_d = '0;
    valid_d    = 1'b0;
    if (squash) begin
      instr_d    = NOP_INSTR;
      pc_plus1_d = '0;
      valid_d    = 1'b0;
    end else if (hold) begin
      instr_d    = instr_q;
      pc_plus1_d = pc_plus1_q;
      valid_d    = valid_q;
    end else if (load) begin
      instr_d    = instr_i;
      pc_plus1_d = pc_plus1_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, IDLE/FETCH/HALT control and IF/ID register.
// HALT_DETECT_EN enables stopping on the HLT opcode; without it HLT is an ordinary word.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(fetch_pkg::NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic [INSTR_W-1:0] im_instr,
  output logic [ADDR_W-1:0]  im_addr,
  output logic               im_rd_en,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic               if_valid,
  output logic               halted
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              fetching;
  logic              halt_entry;

  assign fetching = (state_q == FETCH);
  assign pc_inc   = pc_q + ADDR_W'(1);

`ifdef HALT_DETECT_EN
  // A stalled or redirected HLT is not yet committed to fetch, so it cannot halt
  assign halt_entry = fetching & is_hlt(16'(im_instr)) & ~stall & ~redirect;
`else
  assign halt_entry = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (halt_entry) state_d = HALT;
      HALT:    if (redirect)   state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Redirect wins over stall; HALT entry and HALT freeze the PC on the HLT address
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (!stall && fetching && !halt_entry) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef HALT_DETECT_EN
  logic halted_q, halted_d;

  assign halted_d = (state_d == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign im_addr  = pc_q;
  assign im_rd_en = fetching & ~stall;

  if_id_reg #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .squash     (flush | redirect),
    .hold       (stall),
    .load       (fetching),
    .instr_i    (im_instr),
    .pc_plus1_i (pc_inc),
    .instr_o    (if_instr),
    .pc_plus1_o (if_pc_plus1),
    .valid_o    (if_valid)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized control traffic
// checked against a behavioural fetch model. Honors HALT_DETECT_EN like the design.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] im_instr, im_addr, if_instr, if_pc_plus1;
  logic        im_rd_en, if_valid, halted;

  logic [15:0] mem [0:65535];

`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [15:0] m_pc, m_instr, m_pc1;
  bit          m_idle, m_halted, m_valid;

  always #5 clk = ~clk;

  assign im_instr = mem[im_addr];

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_instr(im_instr), .im_addr(im_addr), .im_rd_en(im_rd_en),
    .if_instr(if_instr), .if_pc_plus1(if_pc_plus1), .if_valid(if_valid), .halted(halted)
  );

  task automatic model_reset();
    m_pc = 16'h0000; m_idle = 1'b1; m_halted = 1'b0;
    m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0;
  endtask

  // Advance one clock; model computes what the stage must hold after this edge
  task automatic step();
    logic [15:0] w, n_pc;
    bit fetching, hlt;
    fetching = !m_idle && !m_halted;
    w = mem[m_pc];
    hlt = HALT_EN && fetching && (w[15:12] == 4'hF) && !stall && !redirect;
    if (redirect)                 n_pc = redirect_pc;
    else if (stall)               n_pc = m_pc;
    else if (fetching && !hlt)    n_pc = m_pc + 16'd1;
    else                          n_pc = m_pc;
    @(posedge clk); #1;
    if (flush || redirect) begin
      m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0;
    end else if (!stall) begin
      if (fetching) begin m_instr = w; m_pc1 = m_pc + 16'd1; m_valid = 1'b1; end
      else begin m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0; end
    end
    m_halted = redirect ? 1'b0 : (m_halted || hlt);
    m_idle = 1'b0;
    m_pc = n_pc;
  endtask

  task automatic apply_reset();
    stall = 0; flush = 0; redirect = 0; redirect_pc = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (im_addr !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", im_addr); else passed++;
    checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0000 || if_pc_plus1 !== 16'h0000)
      $display("FAIL reset_ifid: got v=%b i=%h p=%h want 0/0000/0000", if_valid, if_instr, if_pc_plus1); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passed++;
    apply_reset();
    checks++; if (im_rd_en !== 1'b0) $display("FAIL idle_rd_en: got %b want 0", im_rd_en); else passed++;
  endtask

  task automatic test_stream_and_stall();
    step();
    checks++; if (im_rd_en !== 1'b1 || im_addr !== 16'h0000)
      $display("FAIL first_fetch: got en=%b a=%h want 1/0000", im_rd_en, im_addr); else passed++;
    step();
    checks++; if (if_instr !== 16'h1111 || if_pc_plus1 !== 16'h0001 || if_valid !== 1'b1)
      $display("FAIL stream0: got %h/%h/%b want 1111/0001/1", if_instr, if_pc_plus1, if_valid); else passed++;
    step();
    checks++; if (if_instr !== 16'h2222 || if_pc_plus1 !== 16'h0002)
      $display("FAIL stream1: got %h/%h want 2222/0002", if_instr, if_pc_plus1); else passed++;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (im_addr !== 16'h0002 || if_instr !== 16'h2222 || if_valid !== 1'b1 || im_rd_en !== 1'b0)
        $display("FAIL stall_hold%0d: got a=%h i=%h v=%b en=%b want 0002/2222/1/0", i, im_addr, if_instr, if_valid, im_rd_en);
      else passed++;
    end
    stall = 1'b0;
    step();
    checks++; if (if_instr !== 16'h3333 || if_pc_plus1 !== 16'h0003 || im_addr !== 16'h0003)
      $display("FAIL stall_resume: got %h/%h a=%h want 3333/0003 a=0003", if_instr, if_pc_plus1, im_addr); else passed++;
  endtask

  task automatic test_redirect_over_stall();
    redirect = 1'b1; redirect_pc = 16'h0100; stall = 1'b1;
    step();
    checks++; if (im_addr !== 16'h0100 || if_valid !== 1'b0)
      $display("FAIL redirect_stall: got a=%h v=%b want 0100/0", im_addr, if_valid); else passed++;
    redirect = 1'b0; stall = 1'b0;
    step();
    checks++; if (if_instr !== mem[16'h0100] || if_valid !== 1'b1 || if_pc_plus1 !== 16'h0101)
      $display("FAIL redirect_target: got %h/%b/%h want %h/1/0101", if_instr, if_valid, if_pc_plus1, mem[16'h0100]); else passed++;
  endtask

  task automatic test_flush_over_stall();
    logic [15:0] pc_before;
    pc_before = im_addr;
    flush = 1'b1; stall = 1'b1;
    step();
    checks++; if (if_instr !== 16'h0000 || if_valid !== 1'b0 || im_addr !== pc_before)
      $display("FAIL flush_stall: got i=%h v=%b a=%h want 0000/0/%h", if_instr, if_valid, im_addr, pc_before); else passed++;
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    step();
    step();
    checks++; if (im_addr !== 16'h0000 || if_pc_plus1 !== 16'h0000 || if_instr !== mem[16'hFFFF])
      $display("FAIL pc_wrap: got a=%h p=%h i=%h want 0000/0000/%h", im_addr, if_pc_plus1, if_instr, mem[16'hFFFF]); else passed++;
  endtask

  task automatic test_halt();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (im_addr !== 16'h0000 || if_valid !== 1'b0 || im_rd_en !== 1'b0)
      $display("FAIL async_reset: got a=%h v=%b en=%b want 0000/0/0", im_addr, if_valid, im_rd_en); else passed++;
    apply_reset();
    mem[16'h0005] = 16'hF000;
    repeat (7) step();
    checks++; if (if_instr !== 16'hF000 || if_valid !== 1'b1)
      $display("FAIL hlt_enters_ifid: got %h/%b want f000/1", if_instr, if_valid); else passed++;
`ifdef HALT_DETECT_EN
    checks++; if (halted !== 1'b1 || im_addr !== 16'h0005)
      $display("FAIL halt_entry: got h=%b a=%h want 1/0005", halted, im_addr); else passed++;
    step();
    checks++; if (if_valid !== 1'b0 || im_addr !== 16'h0005 || im_rd_en !== 1'b0 || halted !== 1'b1)
      $display("FAIL halt_hold: got v=%b a=%h en=%b h=%b want 0/0005/0/1", if_valid, im_addr, im_rd_en, halted); else passed++;
`else
    checks++; if (halted !== 1'b0 || im_addr !== 16'h0006)
      $display("FAIL no_halt: got h=%b a=%h want 0/0006", halted, im_addr); else passed++;
    step();
`endif
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    checks++; if (halted !== 1'b0 || im_addr !== 16'h0010)
      $display("FAIL halt_redirect: got h=%b a=%h want 0/0010", halted, im_addr); else passed++;
    step();
    checks++; if (if_instr !== mem[16'h0010] || if_valid !== 1'b1)
      $display("FAIL halt_resume: got %h/%b want %h/1", if_instr, if_valid, mem[16'h0010]); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 32; i++) mem[16'h2000 + 16'($urandom_range(0, 255))] = 16'hF000 | 16'($urandom_range(0, 4095));
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = 16'h2000 + 16'($urandom_range(0, 255));
      step();
      checks++; if (im_addr !== m_pc) $display("FAIL rnd_addr[%0d]: got %h want %h", i, im_addr, m_pc); else passed++;
      checks++; if (im_rd_en !== (!m_idle && !m_halted && !stall))
        $display("FAIL rnd_rd_en[%0d]: got %b want %b", i, im_rd_en, !m_idle && !m_halted && !stall); else passed++;
      checks++; if (if_valid !== m_valid || if_instr !== m_instr)
        $display("FAIL rnd_ifid[%0d]: got %b/%h want %b/%h", i, if_valid, if_instr, m_valid, m_instr); else passed++;
      if (m_valid) begin
        checks++; if (if_pc_plus1 !== m_pc1) $display("FAIL rnd_pc1[%0d]: got %h want %h", i, if_pc_plus1, m_pc1); else passed++;
      end
      checks++; if (halted !== m_halted) $display("FAIL rnd_halted[%0d]: got %b want %b", i, halted, m_halted); else passed++;
    end
    stall = 0; flush = 0; redirect = 0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'($urandom);
      if (mem[a][15:12] == 4'hF) mem[a][15:12] = 4'hE;
    end
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    model_reset();
    test_reset();
    test_stream_and_stall();
    test_redirect_over_stall();
    test_flush_over_stall();
    test_wrap();
    test_halt();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
